cart_mbc: RTL and testbench

CART_MBC -- requirements
Module: cart_mbc

---
 rtl/cart_mbc_pkg.sv | 31 +++
 rtl/mbc1_regs.sv | 83 ++++++++
 rtl/cart_mbc.sv | 115 +++++++++++
 tb/tb_cart_mbc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_mbc_pkg.sv
// Shared constants and types for the MBC1-style cartridge mapper.
// Address regions, the boot-disable register address and the read-source encoding.
package cart_mbc_pkg;

   localparam logic [15:0] ROM0_BASE = 16'h0000;
   localparam logic [15:0] ROM0_LAST = 16'h3FFF;
   localparam logic [15:0] ROMX_BASE = 16'h4000;
   localparam logic [15:0] ROMX_LAST = 16'h7FFF;
   localparam logic [15:0] ERAM_BASE = 16'hA000;
   localparam logic [15:0] ERAM_LAST = 16'hBFFF;
   localparam logic [15:0] BOOT_OFF  = 16'hFF50;

   // Register-write windows inside 0x0000-0x7FFF, selected by addr[14:13]
   localparam logic [1:0] WR_RAM_EN  = 2'd0;
   localparam logic [1:0] WR_BANK_LO = 2'd1;
   localparam logic [1:0] WR_BANK_HI = 2'd2;
   localparam logic [1:0] WR_MODE    = 2'd3;

   typedef enum logic [1:0] {
      SRC_BOOT,
      SRC_ROM,
      SRC_RAM,
      SRC_FF
   } src_e;

   function automatic logic in_region(input logic [15:0] a, input logic [15:0] lo,
                                      input logic [15:0] hi);
      return (a >= lo) && (a <= hi);
   endfunction

endpackage

// File: rtl/mbc1_regs.sv
// MBC1 control registers (boot/RAM enables, bank and mode) and the derived
// ROM/RAM bank numbers for the current bus address.
module mbc1_regs
   import cart_mbc_pkg::*;
#(
   parameter int unsigned ROM_BANKS = 2,
   parameter int unsigned RAM_BANKS = 1,
   localparam int unsigned ROM_BW = $clog2(ROM_BANKS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_i,
   input  logic [15:0]       addr_i,
   input  logic [7:0]        wdata_i,
   output logic              boot_en_o,
   output logic              ram_en_o,
   output logic [ROM_BW-1:0] rom_bank_o,
   output logic [1:0]        ram_bank_o
);

   localparam logic [6:0] ROM_MASK = 7'(ROM_BANKS - 1);
   localparam logic [1:0] RAM_MASK = 2'(((RAM_BANKS > 1) ? RAM_BANKS : 1) - 1);

   logic       boot_en_q, boot_en_d;
   logic       ram_en_q, ram_en_d;
   logic       mode_q, mode_d;
   logic [4:0] bank_lo_q, bank_lo_d;
   logic [1:0] bank_hi_q, bank_hi_d;
   logic [6:0] rom_bank_full;
   logic [6:0] rom_bank_masked;

   always_comb begin
      boot_en_d = boot_en_q;
      ram_en_d  = ram_en_q;
      mode_d    = mode_q;
      bank_lo_d = bank_lo_q;
      bank_hi_d = bank_hi_q;
      if (wr_i && !addr_i[15]) begin
         unique case (addr_i[14:13])
            WR_RAM_EN:  ram_en_d  = (wdata_i[3:0] == 4'hA);
            // Bank 0 is never selectable in the switchable window
            WR_BANK_LO: bank_lo_d = (wdata_i[4:0] == 5'd0) ? 5'd1 : wdata_i[4:0];
            WR_BANK_HI: bank_hi_d = wdata_i[1:0];
            WR_MODE:    mode_d    = wdata_i[0];
         endcase
      end
      // Boot overlay can only be switched off; only reset brings it back
      if (wr_i && (addr_i == BOOT_OFF) && (wdata_i != 8'd0)) begin
         boot_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         boot_en_q <= 1'b1;
         ram_en_q  <= 1'b0;
         mode_q    <= 1'b0;
         bank_lo_q <= 5'd1;
         bank_hi_q <= 2'd0;
      end else begin
         boot_en_q <= boot_en_d;
         ram_en_q  <= ram_en_d;
         mode_q    <= mode_d;
         bank_lo_q <= bank_lo_d;
         bank_hi_q <= bank_hi_d;
      end
   end

   always_comb begin
      if (addr_i[14]) begin
         rom_bank_full = {bank_hi_q, bank_lo_q};
      end else begin
         rom_bank_full = mode_q ? {bank_hi_q, 5'd0} : 7'd0;
      end
      rom_bank_masked = rom_bank_full & ROM_MASK;
   end

   assign rom_bank_o = ROM_BW'(rom_bank_masked);
   assign ram_bank_o = (mode_q ? bank_hi_q : 2'd0) & RAM_MASK;
   assign boot_en_o  = boot_en_q;
   assign ram_en_o   = ram_en_q;

endmodule

// File: rtl/cart_mbc.sv
// Cartridge mapper top: address decode, boot ROM overlay and the one-cycle
// registered read path feeding rdata from boot ROM, cartridge ROM or external RAM.
module cart_mbc
   import cart_mbc_pkg::*;
#(
   parameter int unsigned ROM_BANKS = 2,
   parameter int unsigned RAM_BANKS = 1,
   parameter int unsigned BOOT_SIZE = 256,
   localparam int unsigned ROM_BW  = $clog2(ROM_BANKS),
   localparam int unsigned ROM_AW  = 14 + ROM_BW,
   localparam int unsigned BOOT_AW = $clog2(BOOT_SIZE),
   localparam int unsigned RAM_AW  = 13 + $clog2((RAM_BANKS > 1) ? RAM_BANKS : 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        addr,
   input  logic [7:0]         wdata,
   input  logic               wr,
   input  logic               rd,
   output logic [7:0]         rdata,
   output logic               rdata_valid,
   output logic [ROM_AW-1:0]  rom_addr,
   input  logic [7:0]         rom_data,
   output logic [BOOT_AW-1:0] boot_addr,
   input  logic [7:0]         boot_data,
   output logic [RAM_AW-1:0]  ram_addr,
   output logic [7:0]         ram_wdata,
   output logic               ram_we,
   input  logic [7:0]         ram_data
);

   localparam logic        HAS_RAM    = (RAM_BANKS > 0);
   localparam logic [16:0] BOOT_LIMIT = 17'(BOOT_SIZE);

   logic              boot_en;
   logic              ram_en;
   logic [ROM_BW-1:0] rom_bank;
   logic [1:0]        ram_bank;
   logic              in_rom;
   logic              in_eram;
   logic              in_boot;
   logic              rd_take;
   src_e              src_d, src_q;
   logic              pend_q;
   logic [7:0]        hold_q;
   logic [7:0]        rdata_mux;

   mbc1_regs #(
      .ROM_BANKS (ROM_BANKS),
      .RAM_BANKS (RAM_BANKS)
   ) u_regs (
      .clk        (clk),
      .rst        (rst),
      .wr_i       (wr),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .boot_en_o  (boot_en),
      .ram_en_o   (ram_en),
      .rom_bank_o (rom_bank),
      .ram_bank_o (ram_bank)
   );

   assign in_rom  = in_region(addr, ROM0_BASE, ROMX_LAST);
   assign in_eram = in_region(addr, ERAM_BASE, ERAM_LAST);
   assign in_boot = boot_en && ({1'b0, addr} < BOOT_LIMIT);

   // Memories are synchronous-read, so addresses go out in the request cycle
   assign rom_addr  = {rom_bank, addr[13:0]};
   assign boot_addr = addr[BOOT_AW-1:0];
   assign ram_addr  = RAM_AW'({ram_bank, addr[12:0]});
   assign ram_wdata = wdata;
   assign ram_we    = wr & ram_en & HAS_RAM & in_eram & ~rst;

   // A simultaneous write wins; the read is dropped
   assign rd_take = rd & ~wr;

   always_comb begin
      src_d = SRC_FF;
      if (in_rom) begin
         src_d = in_boot ? SRC_BOOT : SRC_ROM;
      end else if (in_eram && ram_en && HAS_RAM) begin
         src_d = SRC_RAM;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= 1'b0;
         src_q  <= SRC_FF;
         hold_q <= 8'h00;
      end else begin
         pend_q <= rd_take;
         if (rd_take) begin
            src_q <= src_d;
         end
         if (pend_q) begin
            hold_q <= rdata_mux;
         end
      end
   end

   always_comb begin
      rdata_mux = 8'hFF;
      unique case (src_q)
         SRC_BOOT: rdata_mux = boot_data;
         SRC_ROM:  rdata_mux = rom_data;
         SRC_RAM:  rdata_mux = ram_data;
         SRC_FF:   rdata_mux = 8'hFF;
      endcase
   end

   assign rdata       = pend_q ? rdata_mux : hold_q;
   assign rdata_valid = pend_q;

endmodule

// File: tb/tb_cart_mbc.sv
// Bench for cart_mbc: directed scenarios plus random traffic, checked against a
// byte-level model of the mapper's banking rules and its backing memories.
module tb_cart_mbc;

   localparam int unsigned ROM_BANKS = 8;
   localparam int unsigned RAM_BANKS = 4;
   localparam int unsigned BOOT_SIZE = 256;
   localparam int ROM_BYTES = ROM_BANKS * 16384;
   localparam int RAM_BYTES = RAM_BANKS * 8192;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        wr, rd;
   logic [7:0]  rdata;
   logic        rdata_valid;
   logic [16:0] rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  boot_addr;
   logic [7:0]  boot_data;
   logic [14:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [7:0]  ram_data;

   always #5 clk = ~clk;

   cart_mbc #(
      .ROM_BANKS (ROM_BANKS),
      .RAM_BANKS (RAM_BANKS),
      .BOOT_SIZE (BOOT_SIZE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .addr        (addr),
      .wdata       (wdata),
      .wr          (wr),
      .rd          (rd),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .boot_addr   (boot_addr),
      .boot_data   (boot_data),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_we      (ram_we),
      .ram_data    (ram_data)
   );

   logic [7:0] rom_mem  [0:ROM_BYTES-1];
   logic [7:0] boot_mem [0:BOOT_SIZE-1];
   logic [7:0] ram_mem  [0:RAM_BYTES-1];
   logic [7:0] model_ram[0:RAM_BYTES-1];

   always @(posedge clk) begin
      rom_data  <= rom_mem[rom_addr];
      boot_data <= boot_mem[boot_addr];
      ram_data  <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
   end

   // Reference state
   bit         m_boot, m_ram_en, m_mode;
   int         m_lo, m_hi;
   logic [7:0] m_last;
   int         n_cmp = 0;
   int         n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_boot = 1; m_ram_en = 0; m_lo = 1; m_hi = 0; m_mode = 0; m_last = 8'h00;
   endtask

   function automatic int rom_index(input logic [15:0] a);
      int bank;
      if (a < 16'h4000) bank = m_mode ? m_hi * 32 : 0;
      else              bank = m_hi * 32 + m_lo;
      bank = bank % ROM_BANKS;
      return bank * 16384 + (int'(a) % 16384);
   endfunction

   function automatic int ram_index(input logic [15:0] a);
      return ((m_mode ? m_hi : 0) % RAM_BANKS) * 8192 + (int'(a) - 'hA000);
   endfunction

   function automatic logic [7:0] model_read(input logic [15:0] a);
      if (a < 16'h8000) begin
         if (m_boot && a < BOOT_SIZE) return boot_mem[a];
         return rom_mem[rom_index(a)];
      end
      if (a >= 16'hA000 && a < 16'hC000 && m_ram_en) return model_ram[ram_index(a)];
      return 8'hFF;
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [7:0] d);
      if (a < 16'h2000)      m_ram_en = (d[3:0] == 4'hA);
      else if (a < 16'h4000) m_lo = (d[4:0] == 0) ? 1 : int'(d[4:0]);
      else if (a < 16'h6000) m_hi = int'(d[1:0]);
      else if (a < 16'h8000) m_mode = d[0];
      else if (a >= 16'hA000 && a < 16'hC000) begin
         if (m_ram_en) model_ram[ram_index(a)] = d;
      end else if (a == 16'hFF50 && d != 0) m_boot = 0;
   endtask

   task automatic do_rd(input logic [15:0] a);
      logic [7:0] exp;
      addr = a; rd = 1'b1; wr = 1'b0;
      #1;
      if (a < 16'h8000 && !(m_boot && a < BOOT_SIZE)) check("rom_addr", rom_addr, rom_index(a));
      if (a < 16'h8000 && m_boot && a < BOOT_SIZE) check("boot_addr", boot_addr, a[7:0]);
      exp = model_read(a);
      @(posedge clk);
      #1;
      rd = 1'b0;
      check("rd_valid", rdata_valid, 1);
      check("rd_data", rdata, exp);
      m_last = exp;
   endtask

   task automatic do_wr(input logic [15:0] a, input logic [7:0] d);
      bit exp_we;
      addr = a; wdata = d; wr = 1'b1; rd = 1'b0;
      #1;
      exp_we = (a >= 16'hA000 && a < 16'hC000 && m_ram_en);
      check("ram_we", ram_we, exp_we);
      if (exp_we) begin
         check("ram_addr", ram_addr, ram_index(a));
         check("ram_wdata", ram_wdata, d);
      end
      @(posedge clk);
      model_write(a, d);
      #1;
      wr = 1'b0;
   endtask

   logic [15:0] ra;
   logic [7:0]  rd8;
   int unsigned k;

   initial begin
      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0; wdata = 8'h0;
      for (int i = 0; i < ROM_BYTES; i++) rom_mem[i] = 8'($urandom);
      for (int i = 0; i < BOOT_SIZE; i++) boot_mem[i] = 8'($urandom);
      for (int i = 0; i < RAM_BYTES; i++) begin
         ram_mem[i]   = 8'($urandom);
         model_ram[i] = ram_mem[i];
      end
      model_reset();

      // Reset state, and no RAM strobe while reset is held
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", rdata, 8'h00);
      check("rst_valid", rdata_valid, 0);
      addr = 16'hA000; wdata = 8'h33; wr = 1'b1;
      #1;
      check("rst_ram_we", ram_we, 0);
      wr = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Boot overlay, ignored zero write, then disable
      do_rd(16'h0000);
      check("boot_byte0", rdata, boot_mem[0]);
      do_wr(16'hFF50, 8'h00);
      do_rd(16'h0000);
      do_wr(16'hFF50, 8'h01);
      do_rd(16'h0000);
      do_rd(16'h00FF);
      do_rd(16'h0100);

      // ROM banking with zero remap and mask
      do_wr(16'h2000, 8'h00);
      do_rd(16'h4000);
      check("bank1_addr", rom_data === rom_mem[17'h04000], 1);
      do_wr(16'h2000, 8'h0B);
      addr = 16'h4123; rd = 1'b1;
      #1;
      check("bank3_rom_addr", rom_addr, 17'h0C123);
      do_rd(16'h4123);

      // External RAM: disabled reads, then enabled banked write/read
      do_rd(16'hA000);
      check("ram_off_ff", rdata, 8'hFF);
      do_wr(16'h0000, 8'h0A);
      do_wr(16'h6000, 8'h01);
      do_wr(16'h4000, 8'h02);
      addr = 16'hA005; wdata = 8'h5A; wr = 1'b1;
      #1;
      check("ram_addr_4005", ram_addr, 15'h4005);
      do_wr(16'hA005, 8'h5A);
      do_rd(16'hA005);
      check("ram_rd_5a", rdata, 8'h5A);

      // Back-to-back reads across region boundaries
      do_rd(16'h3FFF);
      do_rd(16'h4000);
      do_rd(16'hA000);
      do_rd(16'hFEFF);
      check("last_ff", rdata, 8'hFF);
      @(posedge clk);
      #1;
      check("idle_valid", rdata_valid, 0);
      check("idle_hold", rdata, m_last);

      // Simultaneous rd+wr: write lands, read dropped, rdata holds
      addr = 16'h2000; wdata = 8'h05; rd = 1'b1; wr = 1'b1;
      @(posedge clk);
      model_write(16'h2000, 8'h05);
      #1;
      rd = 1'b0; wr = 1'b0;
      check("rdwr_valid", rdata_valid, 0);
      check("rdwr_hold", rdata, m_last);
      do_rd(16'h4001);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         k   = $urandom_range(0, 9);
         rd8 = 8'($urandom);
         case (k)
            0: do_rd(16'($urandom_range(0, 'h3FFF)));
            1, 2: do_rd(16'($urandom_range('h4000, 'h7FFF)));
            3, 4: do_rd(16'($urandom_range('hA000, 'hBFFF)));
            5: do_rd(16'($urandom_range('h8000, 'hFFFF)));
            6, 7: begin
               ra = 16'($urandom_range(0, 'h7FFF));
               if (ra < 16'h2000 && $urandom_range(0, 1) == 1) rd8[3:0] = 4'hA;
               do_wr(ra, rd8);
            end
            default: do_wr(16'($urandom_range('hA000, 'hBFFF)), rd8);
         endcase
      end

      // Reset the cycle after a read is issued
      addr = 16'h0010; rd = 1'b1; wr = 1'b0;
      @(posedge clk);
      #1;
      rd = 1'b0; rst = 1'b1;
      #1;
      check("rst_mid_valid", rdata_valid, 0);
      check("rst_mid_rdata", rdata, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check("post_rst_valid", rdata_valid, 0);
      do_rd(16'h0010);
      check("post_rst_boot", rdata, boot_mem[16]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
